// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - DMG DIV/TIMA/TMA/TAC timer at FF04-FF07
// Falling-edge tick detector reproduces the DIV/TAC write glitches; overflow reload is delayed one M-cycle.
module gb_timer #(
  parameter logic [15:0] CNT_INIT     = 16'h0000,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  output logic        IRQ_TIMER
);

  localparam logic [1:0] DLY_INIT = 2'(RELOAD_DELAY - 1);

  logic [15:0] cnt, cnt_next;
  logic [7:0]  tima, tma, tma_next;
  logic [2:0]  tac, tac_next;
  logic        prev_sel, sel, sel_bit, tick;
  logic        pending, reload;
  logic [1:0]  dly;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic        unused_rd;

  assign unused_rd = RD;

  assign wr_div  = WR && (ADDR == 16'hFF04);
  assign wr_tima = WR && (ADDR == 16'hFF05);
  assign wr_tma  = WR && (ADDR == 16'hFF06);
  assign wr_tac  = WR && (ADDR == 16'hFF07);

  // Edge detection works on post-write values so DIV/TAC writes can produce a falling edge.
  always_comb begin
    cnt_next = wr_div ? 16'h0000 : cnt + 16'd1;
    tac_next = wr_tac ? MMIO_DATA_out[2:0] : tac;
    tma_next = wr_tma ? MMIO_DATA_out : tma;
    sel_bit  = 1'b0;
    case (tac_next[1:0])
      2'b00: sel_bit = cnt_next[9];
      2'b01: sel_bit = cnt_next[3];
      2'b10: sel_bit = cnt_next[5];
      2'b11: sel_bit = cnt_next[7];
      default: sel_bit = 1'b0;
    endcase
    sel    = tac_next[2] & sel_bit;
    tick   = prev_sel & ~sel;
    reload = pending && (dly == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= CNT_INIT;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= 3'b000;
      prev_sel  <= 1'b0;
      pending   <= 1'b0;
      dly       <= 2'd0;
      IRQ_TIMER <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      tac       <= tac_next;
      tma       <= tma_next;
      prev_sel  <= sel;
      IRQ_TIMER <= reload;
      if (pending && (dly != 2'd0))
        dly <= dly - 2'd1;
      // Reload beats a same-edge TIMA write; a write earlier in the window cancels the reload.
      if (reload) begin
        tima    <= tma_next;
        pending <= 1'b0;
      end else if (wr_tima) begin
        tima    <= MMIO_DATA_out;
        pending <= 1'b0;
      end else if (tick) begin
        if (tima == 8'hFF) begin
          tima    <= 8'h00;
          pending <= 1'b1;
          dly     <= DLY_INIT;
        end else begin
          tima <= tima + 8'd1;
        end
      end
    end
  end

  always_comb begin
    MMIO_DATA_in = 8'hFF;
    case (ADDR)
      16'hFF04: MMIO_DATA_in = cnt[15:8];
      16'hFF05: MMIO_DATA_in = tima;
      16'hFF06: MMIO_DATA_in = tma;
      16'hFF07: MMIO_DATA_in = {5'b11111, tac};
      default:  MMIO_DATA_in = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_gb_timer.sv
// tb/tb_gb_timer.sv - self-checking bench for gb_timer
module tb_gb_timer;

  logic        clk = 1'b0;
  logic        rst, WR, RD, IRQ_TIMER;
  logic [15:0] ADDR;
  logic [7:0]  MMIO_DATA_out, MMIO_DATA_in;
  int          passed = 0;
  int          total = 0;
  int          irq_count = 0;

  gb_timer dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(MMIO_DATA_out), .MMIO_DATA_in(MMIO_DATA_in), .IRQ_TIMER(IRQ_TIMER)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (IRQ_TIMER) irq_count = irq_count + 1;

  typedef struct {
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[12];

  // reference model state
  int          m_cnt;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  bit          m_prev, m_irq;
  int          reload_at;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; WR = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = a; MMIO_DATA_out = d; WR = 1'b1;
    step(1);
    WR = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    ADDR = a;
    #1;
    d = MMIO_DATA_in;
  endtask

  function automatic int bitpos(input logic [1:0] mode);
    case (mode)
      2'b00: return 9;
      2'b01: return 3;
      2'b10: return 5;
      default: return 7;
    endcase
  endfunction

  task automatic model_edge(input int n, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    bit s, tk;
    if (r) begin
      m_cnt = 0; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
      m_prev = 1'b0; m_irq = 1'b0; reload_at = -1;
      return;
    end
    m_cnt = (w && a == 16'hFF04) ? 0 : ((m_cnt + 1) % 65536);
    if (w && a == 16'hFF07) m_tac = d[2:0];
    if (w && a == 16'hFF06) m_tma = d;
    s  = m_tac[2] && (((m_cnt >> bitpos(m_tac[1:0])) & 1) == 1);
    tk = m_prev && !s;
    m_prev = s;
    m_irq = 1'b0;
    if (n == reload_at) begin
      m_tima = m_tma; m_irq = 1'b1; reload_at = -1;
    end else if (w && a == 16'hFF05) begin
      m_tima = d; reload_at = -1;
    end else if (tk) begin
      if (m_tima == 8'hFF) begin
        m_tima = 8'h00; reload_at = n + 4;
      end else begin
        m_tima = m_tima + 8'd1;
      end
    end
  endtask

  // Returns just after edge E0, where TIMA has wrapped FF->00.
  task automatic to_e0(input logic [7:0] tma_v);
    logic [7:0] v;
    int n;
    do_reset();
    wr(16'hFF07, 8'h05);
    wr(16'hFF06, tma_v);
    wr(16'hFF05, 8'hFE);
    n = 0; rd(16'hFF05, v);
    while (v != 8'hFF && n < 40) begin step(1); n++; rd(16'hFF05, v); end
    check("reach_ff", v, 8'hFF);
    n = 0;
    while (v != 8'h00 && n < 40) begin step(1); n++; rd(16'hFF05, v); end
    check("e0_tima00", v, 8'h00);
    check("ff_to_00_clks", n, 16);
  endtask

  initial begin
    logic [7:0] v;
    int ic;
    bit r, w;
    logic [15:0] a;
    logic [7:0] d;
    int k;

    rst = 1'b0; WR = 1'b0; RD = 1'b0; ADDR = 16'h0000; MMIO_DATA_out = 8'h00;

    // reset state and DIV rate
    do_reset();
    ic = irq_count;
    rd(16'hFF04, v); check("rst_div", v, 8'h00);
    rd(16'hFF05, v); check("rst_tima", v, 8'h00);
    rd(16'hFF06, v); check("rst_tma", v, 8'h00);
    rd(16'hFF07, v); check("rst_tac", v, 8'hF8);
    check("rst_irq", IRQ_TIMER, 0);
    step(255); rd(16'hFF04, v); check("div_255", v, 8'h00);
    step(1);   rd(16'hFF04, v); check("div_256", v, 8'h01);
    step(65280); rd(16'hFF04, v); check("div_wrap", v, 8'h00);
    rd(16'hFF07, v); check("tac_idle", v, 8'hF8);
    check("no_irq_idle", irq_count, ic);

    // register write/read table
    vecs[0]  = '{16'hFF06, 8'h5A, 16'hFF06, 8'h5A};
    vecs[1]  = '{16'hFF07, 8'hFF, 16'hFF07, 8'hFF};
    vecs[2]  = '{16'hFF07, 8'hF8, 16'hFF07, 8'hF8};
    vecs[3]  = '{16'hFF07, 8'h03, 16'hFF07, 8'hFB};
    vecs[4]  = '{16'hFF05, 8'h12, 16'hFF05, 8'h12};
    vecs[5]  = '{16'hFF04, 8'h77, 16'hFF04, 8'h00};
    vecs[6]  = '{16'hFF06, 8'hA5, 16'hFF05, 8'h12};
    vecs[7]  = '{16'hFF06, 8'hC3, 16'hFF06, 8'hC3};
    vecs[8]  = '{16'hFF00, 8'h55, 16'hFF00, 8'hFF};
    vecs[9]  = '{16'hFF08, 8'h55, 16'hFF08, 8'hFF};
    vecs[10] = '{16'hFF03, 8'hAA, 16'hFF06, 8'hC3};
    vecs[11] = '{16'hFFFF, 8'h00, 16'hFF07, 8'hFB};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].wa, vecs[i].wd);
      rd(vecs[i].ra, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // overflow with delayed reload and one-clk IRQ
    to_e0(8'h80);
    ic = irq_count;
    step(3);
    rd(16'hFF05, v); check("ovf_e3_tima", v, 8'h00);
    check("ovf_e3_irq", IRQ_TIMER, 0);
    step(1);
    rd(16'hFF05, v); check("ovf_reload", v, 8'h80);
    check("ovf_irq_hi", IRQ_TIMER, 1);
    step(1);
    check("ovf_irq_lo", IRQ_TIMER, 0);
    check("ovf_irq_once", irq_count, ic + 1);

    // TIMA write inside the window cancels the reload
    to_e0(8'h80);
    ic = irq_count;
    step(1);
    wr(16'hFF05, 8'h33);
    step(6);
    rd(16'hFF05, v); check("cancel_tima", v, 8'h33);
    check("cancel_no_irq", irq_count, ic);

    // TIMA write at the reload edge loses
    to_e0(8'h80);
    step(3);
    wr(16'hFF05, 8'h33);
    rd(16'hFF05, v); check("late_wr_tima", v, 8'h80);
    check("late_wr_irq", IRQ_TIMER, 1);

    // TMA written at the reload edge is what gets loaded
    to_e0(8'h80);
    step(3);
    wr(16'hFF06, 8'h11);
    rd(16'hFF05, v); check("tma_same_edge", v, 8'h11);
    check("tma_same_irq", IRQ_TIMER, 1);

    // reset inside the pending window drops the reload
    to_e0(8'h80);
    step(1);
    do_reset();
    ic = irq_count;
    step(10);
    rd(16'hFF05, v); check("rst_pend_tima", v, 8'h00);
    check("rst_pend_no_irq", irq_count, ic);

    // DIV write glitch with cnt[3]=1, then with cnt[3]=0
    do_reset();
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'h40);
    step(6);
    wr(16'hFF04, 8'hAB);
    rd(16'hFF05, v); check("div_glitch_tima", v, 8'h41);
    rd(16'hFF04, v); check("div_glitch_div", v, 8'h00);
    do_reset();
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'h40);
    step(1);
    wr(16'hFF04, 8'h00);
    step(4);
    rd(16'hFF05, v); check("div_noglitch", v, 8'h40);

    // TAC disable glitch with cnt[9]=1, then no further ticks
    do_reset();
    wr(16'hFF07, 8'h04);
    wr(16'hFF05, 8'h20);
    step(598);
    rd(16'hFF05, v); check("tac_pre", v, 8'h20);
    wr(16'hFF07, 8'h00);
    rd(16'hFF05, v); check("tac_glitch", v, 8'h21);
    step(4096);
    rd(16'hFF05, v); check("tac_off_hold", v, 8'h21);
    rd(16'hFF07, v); check("tac_off_read", v, 8'hF8);

    // randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      r = (n == 0) || ($urandom_range(0, 999) == 0);
      w = ($urandom_range(0, 7) == 0);
      k = $urandom_range(0, 31);
      if (k == 0) a = 16'hFF04;
      else if (k <= 12) a = 16'hFF05;
      else if (k <= 20) a = 16'hFF06;
      else if (k <= 28) a = 16'hFF07;
      else a = 16'($urandom);
      d = 8'($urandom);
      if (a == 16'hFF05 && $urandom_range(0, 1) == 1) d = 8'hFE | d[0];
      rst = r; WR = w; ADDR = a; MMIO_DATA_out = d; RD = 1'($urandom);
      step(1);
      model_edge(n, r, w, a, d);
      rst = 1'b0; WR = 1'b0;
      check("rnd_irq", IRQ_TIMER, m_irq);
      rd(16'hFF04, v); check("rnd_div", v, (m_cnt >> 8) & 255);
      rd(16'hFF05, v); check("rnd_tima", v, m_tima);
      rd(16'hFF06, v); check("rnd_tma", v, m_tma);
      rd(16'hFF07, v); check("rnd_tac", v, {5'b11111, m_tac});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
